// File: rtl/morra_pkg.sv
// Shared encodings for the morra cinese (rock-paper-scissors) game block:
// moves, per-manche / game results, FSM state codes and the repeat-move restriction.
package morra_pkg;

  localparam int unsigned MOSSA_W = 2;
  localparam int unsigned ESITO_W = 2;
  localparam int unsigned STATO_W = 3;

  typedef enum logic [MOSSA_W-1:0] {
    MOSSA_NULLA = 2'b00,
    SASSO       = 2'b01,
    CARTA       = 2'b10,
    FORBICE     = 2'b11
  } mossa_e;

  // Used both for the per-manche pulse and for the final game result.
  typedef enum logic [ESITO_W-1:0] {
    ESITO_NESSUNO = 2'b00,
    ESITO_P1      = 2'b01,
    ESITO_P2      = 2'b10,
    ESITO_PARI    = 2'b11
  } esito_e;

  typedef enum logic [STATO_W-1:0] {
    INIZIO = 3'b000,
    VANT1  = 3'b001,
    VANT2  = 3'b010,
    PARI   = 3'b011,
    FINE   = 3'b100
  } stato_e;

  // Last winner and the move they won with; they may not replay it next manche.
  typedef struct packed {
    logic   vld;
    logic   p2;
    mossa_e mossa;
  } vincolo_t;

  function automatic logic batte(input mossa_e a, input mossa_e b);
    return ((a == SASSO)   && (b == FORBICE)) ||
           ((a == CARTA)   && (b == SASSO))   ||
           ((a == FORBICE) && (b == CARTA));
  endfunction

endpackage

// File: rtl/morra_arbitro.sv
// Combinational manche referee: two moves in, winner / draw / invalid out.
module morra_arbitro
  import morra_pkg::*;
(
  input  mossa_e mossa1_i,
  input  mossa_e mossa2_i,
  output esito_e esito_c
);

  always_comb begin
    esito_c = ESITO_NESSUNO;
    if ((mossa1_i != MOSSA_NULLA) && (mossa2_i != MOSSA_NULLA)) begin
      if (mossa1_i == mossa2_i) begin
        esito_c = ESITO_PARI;
      end else if (batte(mossa1_i, mossa2_i)) begin
        esito_c = ESITO_P1;
      end else begin
        esito_c = ESITO_P2;
      end
    end
  end

endmodule

// File: rtl/morra_cinese_param.sv
// Two-player morra cinese game controller: scores manches, enforces the
// no-repeat-winning-move rule and ends the game on lead margin or manche limit.
module morra_cinese_param
  import morra_pkg::*;
#(
  parameter int unsigned MIN_MANCHE = 4,
  parameter int unsigned MARGINE    = 2,
  parameter int unsigned CFG_W      = 4,
  parameter int unsigned MANCHE_W   = 5
) (
  input  logic                clk,
  input  logic                inizia_n,
  input  logic [MOSSA_W-1:0]  primo,
  input  logic [MOSSA_W-1:0]  secondo,
  input  logic                valido,
  output logic [ESITO_W-1:0]  manche,
  output logic [ESITO_W-1:0]  partita,
  output logic [STATO_W-1:0]  stato,
  output logic [MANCHE_W-1:0] punti1,
  output logic [MANCHE_W-1:0] punti2,
  output logic [MANCHE_W-1:0] giocate
);

  // The largest configurable manche limit must fit the counters.
  if ((2 ** CFG_W) - 1 + MIN_MANCHE > (2 ** MANCHE_W) - 1) begin : g_cfg_troppo_largo
    $error("morra_cinese_param: 2^CFG_W-1+MIN_MANCHE exceeds 2^MANCHE_W-1");
  end

  stato_e                stato_q, stato_d;
  esito_e                manche_q, manche_d;
  esito_e                partita_q, partita_d;
  vincolo_t              vincolo_q, vincolo_d;
  logic [MANCHE_W-1:0]   punti1_q, punti1_d;
  logic [MANCHE_W-1:0]   punti2_q, punti2_d;
  logic [MANCHE_W-1:0]   giocate_q, giocate_d;
  logic [MANCHE_W-1:0]   n_max_q;

  mossa_e                mossa1_c, mossa2_c;
  esito_e                esito_c;
  esito_e                leader_c;
  logic                  in_gioco_c;
  logic                  ripetuta_c;
  logic                  conta_c;
  logic                  vince1_c, vince2_c;
  logic [CFG_W-1:0]      cfg_c;
  logic [MANCHE_W-1:0]   n_max_cfg_c;
  logic [MANCHE_W-1:0]   scarto_c;

  assign mossa1_c = mossa_e'(primo);
  assign mossa2_c = mossa_e'(secondo);

  morra_arbitro u_arbitro (
    .mossa1_i (mossa1_c),
    .mossa2_i (mossa2_c),
    .esito_c  (esito_c)
  );

  // Manche limit captured from the move inputs while reset is held.
  assign cfg_c       = CFG_W'({primo, secondo});
  assign n_max_cfg_c = MANCHE_W'(cfg_c) + MANCHE_W'(MIN_MANCHE);

  assign in_gioco_c = (stato_q == PARI) || (stato_q == VANT1) || (stato_q == VANT2);
  assign ripetuta_c = vincolo_q.vld &&
                      ((vincolo_q.p2 ? mossa2_c : mossa1_c) == vincolo_q.mossa);
  assign conta_c    = in_gioco_c && valido && (esito_c != ESITO_NESSUNO) && !ripetuta_c;
  assign vince1_c   = conta_c && (esito_c == ESITO_P1);
  assign vince2_c   = conta_c && (esito_c == ESITO_P2);

  // Counters only move on a counted manche, so they hold in INIZIO and FINE.
  assign punti1_d  = punti1_q  + MANCHE_W'(vince1_c);
  assign punti2_d  = punti2_q  + MANCHE_W'(vince2_c);
  assign giocate_d = giocate_q + MANCHE_W'(conta_c);

  assign scarto_c = (punti1_d >= punti2_d) ? (punti1_d - punti2_d) : (punti2_d - punti1_d);
  assign leader_c = (punti1_d > punti2_d) ? ESITO_P1 :
                    (punti2_d > punti1_d) ? ESITO_P2 : ESITO_PARI;

  always_comb begin
    stato_d   = stato_q;
    manche_d  = ESITO_NESSUNO;
    partita_d = partita_q;
    vincolo_d = vincolo_q;
    case (stato_q)
      INIZIO: stato_d = PARI;
      PARI, VANT1, VANT2: begin
        if (conta_c) begin
          manche_d = esito_c;
          if (esito_c == ESITO_PARI) begin
            vincolo_d = '0;
          end else begin
            vincolo_d.vld   = 1'b1;
            vincolo_d.p2    = (esito_c == ESITO_P2);
            vincolo_d.mossa = (esito_c == ESITO_P2) ? mossa2_c : mossa1_c;
          end
          // Early margin win is checked before the manche limit.
          if ((giocate_d >= MANCHE_W'(MIN_MANCHE)) && (scarto_c >= MANCHE_W'(MARGINE))) begin
            stato_d   = FINE;
            partita_d = leader_c;
          end else if (giocate_d == n_max_q) begin
            stato_d   = FINE;
            partita_d = leader_c;
          end else begin
            case (leader_c)
              ESITO_P1: stato_d = VANT1;
              ESITO_P2: stato_d = VANT2;
              default:  stato_d = PARI;
            endcase
          end
        end
      end
      FINE:    stato_d = FINE;
      default: stato_d = INIZIO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!inizia_n) begin
      stato_q   <= INIZIO;
      manche_q  <= ESITO_NESSUNO;
      partita_q <= ESITO_NESSUNO;
      vincolo_q <= '0;
      punti1_q  <= '0;
      punti2_q  <= '0;
      giocate_q <= '0;
      n_max_q   <= n_max_cfg_c;
    end else begin
      stato_q   <= stato_d;
      manche_q  <= manche_d;
      partita_q <= partita_d;
      vincolo_q <= vincolo_d;
      punti1_q  <= punti1_d;
      punti2_q  <= punti2_d;
      giocate_q <= giocate_d;
    end
  end

  assign manche  = manche_q;
  assign partita = partita_q;
  assign stato   = stato_q;
  assign punti1  = punti1_q;
  assign punti2  = punti2_q;
  assign giocate = giocate_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Bench for morra_cinese_param: directed vector table, short hand sequences,
// then random play checked against a rule-level reference model.
module tb_morra_cinese_param;

  localparam int MIN  = 4;
  localparam int MARG = 2;
  localparam int MW   = 5;

  logic          clk = 1'b0;
  logic          inizia_n;
  logic [1:0]    primo, secondo;
  logic          valido;
  logic [1:0]    manche, partita;
  logic [2:0]    stato;
  logic [MW-1:0] punti1, punti2, giocate;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  morra_cinese_param #(
    .MIN_MANCHE (MIN),
    .MARGINE    (MARG),
    .CFG_W      (4),
    .MANCHE_W   (MW)
  ) dut (
    .clk      (clk),
    .inizia_n (inizia_n),
    .primo    (primo),
    .secondo  (secondo),
    .valido   (valido),
    .manche   (manche),
    .partita  (partita),
    .stato    (stato),
    .punti1   (punti1),
    .punti2   (punti2),
    .giocate  (giocate)
  );

  typedef struct {
    logic       r, v;
    logic [1:0] p, s;
    int         em, ep, est, e1, e2, eg;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] p,
                              input logic [1:0] s, input int em, input int ep,
                              input int est, input int e1, input int e2, input int eg);
    vec_t x;
    x.r = r; x.v = v; x.p = p; x.s = s;
    x.em = em; x.ep = ep; x.est = est; x.e1 = e1; x.e2 = e2; x.eg = eg;
    return x;
  endfunction

  // Reference model: game rules applied directly to integer scores.
  int m_st, m_man, m_par, m_p1, m_p2, m_g, m_nmax, m_rv, m_rp, m_rm;

  function automatic int esito_ref(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    if (a == b) return 3;
    if (a == (b % 3) + 1) return 1;
    return 2;
  endfunction

  task automatic model_step(input logic r, input logic v, input int a, input int b);
    int w, lead, d;
    if (!r) begin
      m_st = 0; m_man = 0; m_par = 0; m_p1 = 0; m_p2 = 0; m_g = 0; m_rv = 0;
      m_nmax = a * 4 + b + MIN;
    end else if (m_st == 0) begin
      m_st = 3; m_man = 0;
    end else if (m_st == 4) begin
      m_man = 0;
    end else begin
      w = v ? esito_ref(a, b) : 0;
      if (w != 0 && m_rv != 0 && ((m_rp == 1 ? a : b) == m_rm)) w = 0;
      m_man = w;
      if (w != 0) begin
        m_g++;
        if (w == 1) begin m_p1++; m_rv = 1; m_rp = 1; m_rm = a; end
        else if (w == 2) begin m_p2++; m_rv = 1; m_rp = 2; m_rm = b; end
        else m_rv = 0;
        lead = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
        d = (m_p1 > m_p2) ? m_p1 - m_p2 : m_p2 - m_p1;
        if (m_g >= MIN && d >= MARG) begin m_par = lead; m_st = 4; end
        else if (m_g == m_nmax) begin m_par = lead; m_st = 4; end
        else m_st = lead;
      end
    end
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] a, input logic [1:0] b);
    inizia_n = r; valido = v; primo = a; secondo = b;
    @(posedge clk);
    model_step(r, v, int'(a), int'(b));
    #1;
  endtask

  task automatic cmp_model(input int idx);
    chk("model manche",  idx, 32'(manche),  32'(m_man));
    chk("model partita", idx, 32'(partita), 32'(m_par));
    chk("model stato",   idx, 32'(stato),   32'(m_st));
    chk("model punti1",  idx, 32'(punti1),  32'(m_p1));
    chk("model punti2",  idx, 32'(punti2),  32'(m_p2));
    chk("model giocate", idx, 32'(giocate), 32'(m_g));
  endtask

  task automatic step_m(input int idx, input logic r, input logic v,
                        input logic [1:0] a, input logic [1:0] b);
    drive(r, v, a, b);
    cmp_model(idx);
  endtask

  initial begin
    inizia_n = 1'b0; valido = 1'b0; primo = 2'b00; secondo = 2'b00;

    //            r  v  p      s      man par st p1 p2 g
    // reset with cfg 0001 -> n_max 5, then first edge goes to PARI
    tab.push_back(mk(0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 3, 0, 0, 0));
    tab.push_back(mk(1, 1, 2'b01, 2'b11, 1, 0, 1, 1, 0, 1));
    tab.push_back(mk(1, 1, 2'b01, 2'b10, 0, 0, 1, 1, 0, 1));
    tab.push_back(mk(1, 1, 2'b00, 2'b10, 0, 0, 1, 1, 0, 1));
    tab.push_back(mk(1, 0, 2'b10, 2'b01, 0, 0, 1, 1, 0, 1));
    tab.push_back(mk(1, 1, 2'b10, 2'b10, 3, 0, 1, 1, 0, 2));
    tab.push_back(mk(1, 1, 2'b11, 2'b01, 2, 0, 3, 1, 1, 3));
    tab.push_back(mk(1, 1, 2'b10, 2'b01, 0, 0, 3, 1, 1, 3));
    tab.push_back(mk(1, 1, 2'b10, 2'b11, 2, 0, 2, 1, 2, 4));
    tab.push_back(mk(1, 1, 2'b01, 2'b01, 3, 2, 4, 1, 2, 5));
    tab.push_back(mk(1, 1, 2'b10, 2'b01, 0, 2, 4, 1, 2, 5));
    // reset from FINE with valido high, cfg 1111 -> n_max 19
    tab.push_back(mk(0, 1, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 3, 0, 0, 0));
    tab.push_back(mk(1, 1, 2'b01, 2'b11, 1, 0, 1, 1, 0, 1));
    tab.push_back(mk(1, 1, 2'b10, 2'b01, 1, 0, 1, 2, 0, 2));
    tab.push_back(mk(1, 1, 2'b11, 2'b10, 1, 0, 1, 3, 0, 3));
    tab.push_back(mk(1, 1, 2'b01, 2'b01, 3, 1, 4, 3, 0, 4));
    // cfg 0000 -> n_max 4, tied at the limit
    tab.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 3, 0, 0, 0));
    tab.push_back(mk(1, 1, 2'b01, 2'b11, 1, 0, 1, 1, 0, 1));
    tab.push_back(mk(1, 1, 2'b11, 2'b01, 2, 0, 3, 1, 1, 2));
    tab.push_back(mk(1, 1, 2'b10, 2'b10, 3, 0, 3, 1, 1, 3));
    tab.push_back(mk(1, 1, 2'b10, 2'b10, 3, 3, 4, 1, 1, 4));
    // VANT2 with punti2=2 (lead 2 before MIN manches), then mid-game reset
    tab.push_back(mk(0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 3, 0, 0, 0));
    tab.push_back(mk(1, 1, 2'b11, 2'b01, 2, 0, 2, 0, 1, 1));
    tab.push_back(mk(1, 1, 2'b01, 2'b10, 2, 0, 2, 0, 2, 2));
    tab.push_back(mk(0, 1, 2'b01, 2'b11, 0, 0, 0, 0, 0, 0));
    // legal moves in INIZIO are ignored
    tab.push_back(mk(1, 1, 2'b01, 2'b11, 0, 0, 3, 0, 0, 0));

    foreach (tab[i]) begin
      drive(tab[i].r, tab[i].v, tab[i].p, tab[i].s);
      chk("row manche",  i, 32'(manche),  32'(tab[i].em));
      chk("row partita", i, 32'(partita), 32'(tab[i].ep));
      chk("row stato",   i, 32'(stato),   32'(tab[i].est));
      chk("row punti1",  i, 32'(punti1),  32'(tab[i].e1));
      chk("row punti2",  i, 32'(punti2),  32'(tab[i].e2));
      chk("row giocate", i, 32'(giocate), 32'(tab[i].eg));
    end

    // Restriction survives an invalid manche and is cleared by a draw.
    step_m(100, 0, 0, 2'b00, 2'b00);
    step_m(101, 1, 0, 2'b00, 2'b00);
    step_m(102, 1, 1, 2'b01, 2'b11);
    step_m(103, 1, 1, 2'b00, 2'b10);
    step_m(104, 1, 1, 2'b01, 2'b11);
    step_m(105, 1, 1, 2'b10, 2'b10);
    step_m(106, 1, 1, 2'b01, 2'b11);
    step_m(107, 1, 1, 2'b11, 2'b10);
    step_m(108, 1, 1, 2'b11, 2'b01);
    step_m(109, 1, 0, 2'b01, 2'b11);

    // Random play against the reference model.
    step_m(200, 0, 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    for (int k = 0; k < 2500; k++) begin
      logic r, v;
      r = ($urandom_range(0, 39) != 0);
      v = ($urandom_range(0, 4) != 0);
      step_m(1000 + k, r, v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
